// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: checks VGA sync timing, locks after clean frames and captures active pixels
// Ports: clk, rst (sync, active-high); pix_en pixel strobe; Hsync/Vsync active-low syncs;
//        vgaRed/vgaGreen/vgaBlue colour in; x, y, rgb, pix_valid captured pixel;
//        locked timing verified; frame_done end of active frame; h_err/v_err error pulses.
module vga_rx_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33,
  parameter int SYNC_TOL = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        Hsync,
  input  logic        Vsync,
  input  logic [3:0]  vgaRed,
  input  logic [3:0]  vgaGreen,
  input  logic [3:0]  vgaBlue,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pix_valid,
  output logic [11:0] rgb,
  output logic        locked,
  output logic        frame_done,
  output logic        h_err,
  output logic        v_err
);
  localparam logic [11:0] HT = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [11:0] VT = 12'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [9:0] HB = 10'(H_BACK);
  localparam logic [9:0] HE = 10'(H_BACK + H_ACTIVE - 1);
  localparam logic [9:0] VB = 10'(V_BACK);
  localparam logic [9:0] VE = 10'(V_BACK + V_ACTIVE - 1);
  localparam logic [6:0] HS_MIN = 7'(H_SYNC - SYNC_TOL);
  localparam logic [6:0] HS_MAX = 7'(H_SYNC + SYNC_TOL);
  localparam logic [6:0] VS_MIN = 7'(V_SYNC - SYNC_TOL);
  localparam logic [6:0] VS_MAX = 7'(V_SYNC + SYNC_TOL);
  localparam logic [7:0] LF = 8'(LOCK_FRAMES);
  typedef enum logic [1:0] {SEARCH, TRAIN, LOCK} state_t;
  state_t state, nxt;
  logic h_prev, v_prev, h_seen, v_seen;
  logic [9:0] hcnt, vcnt, hc, vc;
  logic [6:0] hsw, vsw;
  logic [11:0] lcnt, fcnt, fc;
  logic [7:0] clean;
  logic h_rise, h_fall, v_rise, he, ve, err, act;
  // hc/vc/fc are the counts as seen by the current sample, so the active window and
  // frame length are judged on this sample rather than on last sample's registers
  always_comb begin
    h_rise = ~h_prev & Hsync;
    h_fall = h_prev & ~Hsync;
    v_rise = ~v_prev & Vsync;
    hc = h_rise ? '0 : hcnt + {9'd0, hcnt != 10'h3ff};
    vc = v_rise ? '0 : vcnt + {9'd0, h_rise && vcnt != 10'h3ff};
    fc = fcnt + {11'd0, h_rise && fcnt != 12'hfff};
    he = (h_rise && (hsw < HS_MIN || hsw > HS_MAX)) || (h_fall && h_seen && lcnt != HT);
    ve = v_rise && (vsw < VS_MIN || vsw > VS_MAX || (v_seen && fc != VT));
    err = he | ve;
    act = hc >= HB && hc <= HE && vc >= VB && vc <= VE;
    nxt = state == SEARCH ? (v_rise ? TRAIN : SEARCH)
        : err ? SEARCH
        : (state == TRAIN && v_rise && clean + 8'd1 == LF) ? LOCK : state;
  end
  always_ff @(posedge clk) begin
    pix_valid <= 1'b0;
    frame_done <= 1'b0;
    h_err <= 1'b0;
    v_err <= 1'b0;
    if (rst) begin
      state <= SEARCH;
      h_prev <= 1'b1;
      v_prev <= 1'b1;
      h_seen <= 1'b0;
      v_seen <= 1'b0;
      hcnt <= '0;
      vcnt <= '0;
      hsw <= '0;
      vsw <= '0;
      lcnt <= '0;
      fcnt <= '0;
      clean <= '0;
      x <= '0;
      y <= '0;
      rgb <= '0;
      locked <= 1'b0;
    end else if (pix_en) begin
      h_prev <= Hsync;
      v_prev <= Vsync;
      hcnt <= hc;
      vcnt <= vc;
      hsw <= Hsync ? '0 : hsw + {6'd0, hsw != 7'h7f};
      vsw <= Vsync ? '0 : vsw + {6'd0, h_rise && vsw != 7'h7f};
      lcnt <= h_fall ? 12'd1 : lcnt + {11'd0, lcnt != 12'hfff};
      fcnt <= v_rise ? '0 : fc;
      // dropping back to search restarts both interval checks from scratch
      h_seen <= (h_seen | h_fall) & ~(err && state != SEARCH);
      v_seen <= (v_seen | v_rise) & ~(err && state != SEARCH);
      clean <= state == SEARCH ? '0 : (state == TRAIN && v_rise && !err) ? clean + 8'd1 : clean;
      h_err <= he;
      v_err <= ve;
      state <= nxt;
      locked <= nxt == LOCK;
      if (state == LOCK && !err && act) begin
        pix_valid <= 1'b1;
        x <= hc - HB;
        y <= vc - VB;
        rgb <= {vgaRed, vgaGreen, vgaBlue};
        frame_done <= hc == HE && vc == VE;
      end
    end
  end
endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: directed and randomized stream checks of vga_rx_monitor against a timestamp model
module tb_vga_rx_monitor;
  localparam int H_ACTIVE = 8, H_FRONT = 2, H_SYNC = 4, H_BACK = 3;
  localparam int V_ACTIVE = 6, V_FRONT = 1, V_SYNC = 2, V_BACK = 2;
  localparam int SYNC_TOL = 1, LOCK_FRAMES = 2;
  localparam int HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int FULL = H_ACTIVE * V_ACTIVE;
  logic clk = 1'b0, rst, pix_en, Hsync, Vsync;
  logic [3:0] vgaRed, vgaGreen, vgaBlue;
  logic [9:0] x, y;
  logic [11:0] rgb;
  logic pix_valid, locked, frame_done, h_err, v_err;
  int tests, fails;
  int n_pv, n_fd, n_he, n_ve;
  bit got;
  logic [9:0] fx, fy, dx, dy;
  logic [11:0] frgb;
  int n, t_hf, t_hr, nr, nr_vr, nr_vf, mode, clean;
  bit hs_q, vs_q, seen_h, seen_v;
  logic [9:0] ex, ey;
  logic [11:0] ergb;
  logic epv, efd, elk, ehe, eve;
  vga_rx_monitor #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .SYNC_TOL(SYNC_TOL), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .Hsync(Hsync), .Vsync(Vsync),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .x(x), .y(y), .pix_valid(pix_valid), .rgb(rgb), .locked(locked),
    .frame_done(frame_done), .h_err(h_err), .v_err(v_err)
  );
  always #5 clk = ~clk;
  function automatic int min2(input int a, input int b);
    return a < b ? a : b;
  endfunction
  // Reference: per-sample timestamps of the last sync edges and a running count of
  // Hsync rises; widths and lengths are differences of those, positions are offsets.
  task automatic model(input bit r, input bit en, input bit hs, input bit vs, input logic [11:0] c);
    bit hr, hf, vr, vf, he, ve, err;
    int hc, vc, nr0, w;
    epv = 0; efd = 0; ehe = 0; eve = 0;
    if (r) begin
      n = 0; t_hf = 0; t_hr = -1; nr = 0; nr_vr = 0; nr_vf = 0; hs_q = 1; vs_q = 1;
      seen_h = 0; seen_v = 0; mode = 0; clean = 0; ex = 0; ey = 0; ergb = 0; elk = 0;
    end else if (en) begin
      hr = !hs_q && hs; hf = hs_q && !hs; vr = !vs_q && vs; vf = vs_q && !vs;
      he = 0; ve = 0;
      if (hr) begin
        w = min2(n - t_hf, 127);
        he = w < H_SYNC - SYNC_TOL || w > H_SYNC + SYNC_TOL;
        t_hr = n;
      end
      if (hf) begin
        if (seen_h && min2(n - t_hf, 4095) != HT) he = 1;
        seen_h = 1; t_hf = n;
      end
      hc = min2(n - t_hr, 1023);
      nr0 = nr;
      if (hr) nr++;
      if (vf) nr_vf = nr0;
      if (vr) begin
        w = min2(nr0 - nr_vf, 127);
        ve = w < V_SYNC - SYNC_TOL || w > V_SYNC + SYNC_TOL;
        if (seen_v && nr - nr_vr != VT) ve = 1;
        seen_v = 1; nr_vr = nr;
      end
      vc = min2(nr - nr_vr, 1023);
      err = he || ve;
      if (mode == 2 && !err && hc >= H_BACK && hc < H_BACK + H_ACTIVE && vc >= V_BACK && vc < V_BACK + V_ACTIVE) begin
        epv = 1; ex = 10'(hc - H_BACK); ey = 10'(vc - V_BACK); ergb = c;
        efd = (hc - H_BACK == H_ACTIVE - 1) && (vc - V_BACK == V_ACTIVE - 1);
      end
      if (mode == 0) begin
        clean = 0;
        if (vr) mode = 1;
      end else if (err) begin
        mode = 0; clean = 0; seen_h = 0; seen_v = 0;
      end else if (vr && mode == 1) begin
        clean++;
        if (clean == LOCK_FRAMES) mode = 2;
      end
      elk = mode == 2; ehe = he; eve = ve; hs_q = hs; vs_q = vs; n++;
    end
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input bit r, input bit en, input bit hs, input bit vs, input logic [11:0] c);
    rst = r; pix_en = en; Hsync = hs; Vsync = vs; {vgaRed, vgaGreen, vgaBlue} = c;
    @(posedge clk);
    model(r, en, hs, vs, c);
    #1;
    if (pix_valid === 1'b1) begin
      n_pv++;
      if (!got) begin got = 1; fx = x; fy = y; frgb = rgb; end
    end
    if (frame_done === 1'b1) begin n_fd++; dx = x; dy = y; end
    if (h_err === 1'b1) n_he++;
    if (v_err === 1'b1) n_ve++;
    tests++;
    assert ({x, y, rgb, pix_valid, locked, frame_done, h_err, v_err} === {ex, ey, ergb, epv, elk, efd, ehe, eve}) else begin
      fails++;
      $error("FAIL outputs at sample %0d: observed x=%0d y=%0d rgb=%h pv=%b lk=%b fd=%b he=%b ve=%b expected x=%0d y=%0d rgb=%h pv=%b lk=%b fd=%b he=%b ve=%b",
        n, x, y, rgb, pix_valid, locked, frame_done, h_err, v_err, ex, ey, ergb, epv, elk, efd, ehe, eve);
    end
  endtask
  // one pixel strobe followed by 1..3 idle clocks carrying junk that must be ignored
  task automatic samp(input bit r, input bit hs, input bit vs, input logic [11:0] c);
    tick(r, 1'b1, hs, vs, c);
    repeat ($urandom_range(1, 3)) tick(1'b0, 1'b0, 1'($urandom), 1'($urandom), 12'($urandom));
  endtask
  // line p=0 is the Hsync rise; sync occupies the last H_SYNC samples, plus lead_n leading
  // samples on line lead_l; long_l gets one extra sample; rst pulses at (rst_l, rst_p)
  task automatic frame(input bit pat, input int nl, input int long_l, input int lead_l, input int lead_n,
                       input int vs_n, input int rst_l, input int rst_p);
    for (int l = 0; l < nl; l++)
      for (int p = 0; p < HT + int'(l == long_l); p++) begin
        bit hs, vs;
        logic [3:0] px, py;
        logic [11:0] c;
        hs = !(p < (l == lead_l ? lead_n : 0) || p >= HT + int'(l == long_l) - H_SYNC);
        vs = l < nl - vs_n;
        px = 4'(p - H_BACK);
        py = 4'(l - V_BACK);
        c = pat ? {px, py, 4'hA} : 12'($urandom);
        samp(l == rst_l && p == rst_p, hs, vs, c);
      end
  endtask
  task automatic clr();
    n_pv = 0; n_fd = 0; n_he = 0; n_ve = 0; got = 0;
  endtask
  initial begin
    tests = 0; fails = 0;
    rst = 1; pix_en = 0; Hsync = 1; Vsync = 1; {vgaRed, vgaGreen, vgaBlue} = '0;
    clr();
    repeat (3) tick(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom));
    chk("reset_outputs", {x, y, rgb, pix_valid, locked, frame_done, h_err, v_err}, 0);
    repeat (3) frame(1, VT, -1, -1, 0, V_SYNC, -1, -1);
    chk("unlocked_before_3rd_vrise", locked, 0);
    clr();
    frame(1, VT, -1, -1, 0, V_SYNC, -1, -1);
    chk("locked_nominal", locked, 1);
    chk("nominal_pix_count", n_pv, FULL);
    chk("first_pix_xy", {fx, fy}, 0);
    chk("first_pix_rgb", frgb, 12'h00A);
    chk("frame_done_count", n_fd, 1);
    chk("frame_done_xy", {dx, dy}, {10'(H_ACTIVE - 1), 10'(V_ACTIVE - 1)});
    chk("nominal_no_errors", n_he + n_ve, 0);
    clr();
    frame(0, VT, V_BACK + 2, -1, 0, V_SYNC, -1, -1);
    chk("long_line_herr", n_he, 1);
    chk("long_line_unlocked", locked, 0);
    chk("long_line_pix", n_pv, 3 * H_ACTIVE);
    clr();
    repeat (2) frame(0, VT, -1, -1, 0, V_SYNC, -1, -1);
    chk("long_training_no_pix", n_pv, 0);
    frame(0, VT, -1, -1, 0, V_SYNC, -1, -1);
    chk("long_relocked", locked, 1);
    chk("long_relock_pix", n_pv, FULL);
    clr();
    frame(0, VT, -1, V_BACK + 1, 2, 1, -1, -1);
    chk("wide_hsync_herr", n_he, 1);
    chk("wide_hsync_unlocked", locked, 0);
    chk("wide_hsync_pix", n_pv, H_ACTIVE);
    repeat (3) frame(0, VT, -1, -1, 0, V_SYNC, -1, -1);
    chk("narrow_vsync_no_verr", n_ve, 0);
    chk("narrow_vsync_relocked", locked, 1);
    clr();
    frame(0, VT - 1, -1, -1, 0, V_SYNC, -1, -1);
    chk("short_frame_pix", n_pv, FULL);
    clr();
    frame(0, VT, -1, -1, 0, V_SYNC, -1, -1);
    chk("short_frame_verr", n_ve, 1);
    chk("short_frame_unlocked", locked, 0);
    repeat (2) frame(0, VT, -1, -1, 0, V_SYNC, -1, -1);
    chk("short_training_no_pix", n_pv, 0);
    chk("short_still_unlocked", locked, 0);
    frame(0, VT, -1, -1, 0, V_SYNC, -1, -1);
    chk("short_relocked", locked, 1);
    chk("short_relock_pix", n_pv, FULL);
    clr();
    frame(0, VT, -1, -1, 0, V_SYNC, V_BACK + 3, H_BACK + 5);
    chk("midframe_rst_pix", n_pv, 3 * H_ACTIVE + 5);
    chk("midframe_rst_unlocked", locked, 0);
    clr();
    repeat (2) frame(0, VT, -1, -1, 0, V_SYNC, -1, -1);
    chk("rst_retrain_no_pix", n_pv, 0);
    frame(0, VT, -1, -1, 0, V_SYNC, -1, -1);
    chk("rst_relocked", locked, 1);
    chk("rst_relock_pix", n_pv, FULL);
    for (int k = 0; k < 4; k++)
      frame(0, VT, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, VT - 1)) : -1,
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, VT - 1)) : -1,
            int'($urandom_range(1, 3)), V_SYNC, -1, -1);
    frame(0, VT, -1, -1, 0, V_SYNC, -1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
